// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline stage.
// Captures memory-stage results and holds load entries until their data arrives.
// Aligns and sign- or zero-extends load data, then selects the writeback source.
// Drives the register-file write port so that each instruction is written at most once.
// Optional feature macro: WB_RETIRE_COUNT_EN adds a 32-bit retired-instruction counter.
module mem_wb_stage #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic                     in_regwrite,
   input  logic [ADDRESS_WIDTH-1:0] in_rd,
   input  logic [DATA_WIDTH-1:0]    in_alu_result,
   input  logic [DATA_WIDTH-1:0]    in_pc_plus4,
   input  logic [1:0]               in_wb_sel,
   input  logic [1:0]               in_load_size,
   input  logic                     in_load_unsigned,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   input  logic                     mem_rdata_valid,
   output logic                     wb_busy,
   output logic [ADDRESS_WIDTH-1:0] write_addr,
   output logic [DATA_WIDTH-1:0]    write_data,
`ifdef WB_RETIRE_COUNT_EN
   output logic [31:0]              retire_count,
`endif
   output logic                     regwrite_en
);

   typedef enum logic [1:0] {
      ST_EMPTY    = 2'b00,
      ST_WAIT_MEM = 2'b01,
      ST_READY    = 2'b10
   } state_t;

   localparam logic [1:0] WB_LOAD = 2'b01;
   localparam logic [1:0] WB_PC4  = 2'b10;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   state_t                   state_r;
   logic                     valid_r;
   logic                     committed_r;
   logic                     regwrite_r;
   logic [ADDRESS_WIDTH-1:0] rd_r;
   logic [DATA_WIDTH-1:0]    alu_r;
   logic [DATA_WIDTH-1:0]    pc4_r;
   logic [1:0]               wb_sel_r;
   logic [1:0]               load_size_r;
   logic                     load_unsigned_r;
   logic [DATA_WIDTH-1:0]    load_buf_r;

   logic                     accept_s;
   logic                     in_live_s;
   logic [DATA_WIDTH-1:0]    sel_data_s;

   // Extract the addressed byte/half/word lane and extend it to the full datapath.
   function automatic logic [DATA_WIDTH-1:0] align_load(
      input logic [DATA_WIDTH-1:0] word,
      input logic [1:0]            offset,
      input logic [1:0]            size,
      input logic                  is_unsigned
   );
      logic [7:0]            b;
      logic [15:0]           h;
      logic [DATA_WIDTH-1:0] r;
      case (offset)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         2'b11:   b = word[31:24];
         default: b = word[7:0];
      endcase
      h = offset[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_BYTE: r = {{(DATA_WIDTH-8){~is_unsigned & b[7]}}, b};
         SZ_HALF: r = {{(DATA_WIDTH-16){~is_unsigned & h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // A new entry enters only when nothing downstream holds and no load is outstanding.
   assign accept_s  = !stall && !wb_busy;
   assign in_live_s = in_valid && !flush;

   // Stage state machine: capture, wait for load data, and single-commit tracking.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r         <= ST_EMPTY;
         valid_r         <= 1'b0;
         committed_r     <= 1'b0;
         regwrite_r      <= 1'b0;
         rd_r            <= {ADDRESS_WIDTH{1'b0}};
         alu_r           <= {DATA_WIDTH{1'b0}};
         pc4_r           <= {DATA_WIDTH{1'b0}};
         wb_sel_r        <= 2'b00;
         load_size_r     <= 2'b00;
         load_unsigned_r <= 1'b0;
         load_buf_r      <= {DATA_WIDTH{1'b0}};
      end else begin
         case (state_r)
            ST_WAIT_MEM: begin
               // Load data is taken even while stalled; the entry cannot be replaced here.
               if (mem_rdata_valid) begin
                  load_buf_r <= align_load(mem_rdata, alu_r[1:0], load_size_r, load_unsigned_r);
                  state_r    <= ST_READY;
               end
            end
            ST_READY: begin
               // A held entry has already presented its write once; suppress repeats.
               if (!accept_s) begin
                  committed_r <= 1'b1;
               end
            end
            default: begin
            end
         endcase
         if (accept_s) begin
            valid_r         <= in_live_s;
            committed_r     <= 1'b0;
            regwrite_r      <= in_regwrite;
            rd_r            <= in_rd;
            alu_r           <= in_alu_result;
            pc4_r           <= in_pc_plus4;
            wb_sel_r        <= in_wb_sel;
            load_size_r     <= in_load_size;
            load_unsigned_r <= in_load_unsigned;
            if (!in_live_s) begin
               state_r <= ST_EMPTY;
            end else if (in_wb_sel == WB_LOAD) begin
               state_r <= ST_WAIT_MEM;
            end else begin
               state_r <= ST_READY;
            end
         end
      end
   end

`ifdef WB_RETIRE_COUNT_EN
   // Count each valid entry once, on the edge where it commits or leaves uncommitted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         retire_count <= 32'd0;
      end else if ((state_r == ST_READY) && valid_r && !committed_r) begin
         retire_count <= retire_count + 32'd1;
      end else begin
         retire_count <= retire_count;
      end
   end
`endif

   // Writeback source select; code 11 falls back to the ALU result.
   always_comb begin
      sel_data_s = alu_r;
      case (wb_sel_r)
         WB_LOAD: sel_data_s = load_buf_r;
         WB_PC4:  sel_data_s = pc4_r;
         default: sel_data_s = alu_r;
      endcase
   end

   // Register-file write port, decoded purely from stage registers.
   always_comb begin
      wb_busy     = (state_r == ST_WAIT_MEM);
      write_addr  = valid_r ? rd_r : {ADDRESS_WIDTH{1'b0}};
      regwrite_en = 1'b0;
      write_data  = {DATA_WIDTH{1'b0}};
      if (state_r == ST_READY) begin
         regwrite_en = valid_r && regwrite_r && (rd_r != {ADDRESS_WIDTH{1'b0}}) && !committed_r;
         write_data  = sel_data_s;
      end else begin
         regwrite_en = 1'b0;
         write_data  = {DATA_WIDTH{1'b0}};
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed self-checking bench for mem_wb_stage.
// Expected register-file writes are queued when stimulus is driven and
// compared by a monitor whenever the stage asserts regwrite_en.
module tb_mem_wb_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic        in_regwrite;
   logic [4:0]  in_rd;
   logic [31:0] in_alu_result;
   logic [31:0] in_pc_plus4;
   logic [1:0]  in_wb_sel;
   logic [1:0]  in_load_size;
   logic        in_load_unsigned;
   logic [31:0] mem_rdata;
   logic        mem_rdata_valid;
   logic        wb_busy;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic        regwrite_en;
`ifdef WB_RETIRE_COUNT_EN
   logic [31:0] retire_count;
   logic [31:0] rc0;
`endif

   int          errors = 0;
   int          checks = 0;
   logic [36:0] exp_q[$];

   mem_wb_stage #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall            (stall),
      .flush            (flush),
      .in_valid         (in_valid),
      .in_regwrite      (in_regwrite),
      .in_rd            (in_rd),
      .in_alu_result    (in_alu_result),
      .in_pc_plus4      (in_pc_plus4),
      .in_wb_sel        (in_wb_sel),
      .in_load_size     (in_load_size),
      .in_load_unsigned (in_load_unsigned),
      .mem_rdata        (mem_rdata),
      .mem_rdata_valid  (mem_rdata_valid),
      .wb_busy          (wb_busy),
      .write_addr       (write_addr),
      .write_data       (write_data),
`ifdef WB_RETIRE_COUNT_EN
      .retire_count     (retire_count),
`endif
      .regwrite_en      (regwrite_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard monitor: every observed write must match the oldest queued write.
   always @(negedge clk) begin
      if (regwrite_en) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_write observed addr=%0d data=%h expected no write", write_addr, write_data);
         end
         if (exp_q.size() != 0) begin
            logic [36:0] e;
            e = exp_q.pop_front();
            checks++;
            assert ({write_addr, write_data} === e) else begin
               errors++;
               $error("FAIL write_port observed addr=%0d data=%h expected addr=%0d data=%h",
                      write_addr, write_data, e[36:32], e[31:0]);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_write(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   task automatic idle();
      in_valid         = 1'b0;
      in_regwrite      = 1'b0;
      in_rd            = 5'd0;
      in_alu_result    = 32'd0;
      in_pc_plus4      = 32'd0;
      in_wb_sel        = 2'b00;
      in_load_size     = 2'b00;
      in_load_unsigned = 1'b0;
      flush            = 1'b0;
   endtask

   task automatic set_entry(input logic rw, input logic [4:0] rd, input logic [31:0] alu,
                            input logic [31:0] pc4, input logic [1:0] sel, input logic [1:0] sz,
                            input logic uns, input logic fl);
      in_valid         = 1'b1;
      in_regwrite      = rw;
      in_rd            = rd;
      in_alu_result    = alu;
      in_pc_plus4      = pc4;
      in_wb_sel        = sel;
      in_load_size     = sz;
      in_load_unsigned = uns;
      flush            = fl;
   endtask

   // Load entry: data arrives after `delay` busy cycles; one write of `expd` if `wr`.
   task automatic do_load(input string tag, input logic [4:0] rd, input logic [31:0] alu,
                          input logic [1:0] sz, input logic uns, input logic [31:0] rdata,
                          input logic [31:0] expd, input int delay, input logic wr);
      set_entry(1'b1, rd, alu, 32'd0, 2'b01, sz, uns, 1'b0);
      step();
      idle();
      for (int i = 0; i < delay; i++) begin
         chk({tag, "_busy"}, {31'd0, wb_busy}, 32'd1);
         chk({tag, "_no_we"}, {31'd0, regwrite_en}, 32'd0);
         step();
      end
      mem_rdata       = rdata;
      mem_rdata_valid = 1'b1;
      if (wr) push_write(rd, expd);
      step();
      mem_rdata_valid = 1'b0;
      chk({tag, "_busy_done"}, {31'd0, wb_busy}, 32'd0);
      chk({tag, "_we"}, {31'd0, regwrite_en}, {31'd0, wr});
      step();
   endtask

   initial begin
      rst             = 1'b1;
      stall           = 1'b0;
      mem_rdata       = 32'd0;
      mem_rdata_valid = 1'b0;
      idle();
      #12;
      chk("rst_busy", {31'd0, wb_busy}, 32'd0);
      chk("rst_we", {31'd0, regwrite_en}, 32'd0);
      chk("rst_addr", {27'd0, write_addr}, 32'd0);
      chk("rst_data", write_data, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // ALU writeback, one cycle only
      set_entry(1'b1, 5'd5, 32'h0000_1234, 32'h0000_0010, 2'b00, 2'b00, 1'b0, 1'b0);
      push_write(5'd5, 32'h0000_1234);
      step();
      idle();
      chk("alu_we", {31'd0, regwrite_en}, 32'd1);
      chk("alu_addr", {27'd0, write_addr}, 32'd5);
      chk("alu_data", write_data, 32'h0000_1234);
      step();
      chk("alu_we_gone", {31'd0, regwrite_en}, 32'd0);

      // PC+4 source and the 11 encoding falling back to ALU
      set_entry(1'b1, 5'd1, 32'hDEAD_BEEF, 32'h0000_0100, 2'b10, 2'b00, 1'b0, 1'b0);
      push_write(5'd1, 32'h0000_0100);
      step();
      set_entry(1'b1, 5'd2, 32'h1357_9BDF, 32'h0000_0200, 2'b11, 2'b00, 1'b0, 1'b0);
      push_write(5'd2, 32'h1357_9BDF);
      step();
      idle();
      chk("sel11_data", write_data, 32'h1357_9BDF);
      step();

      // Loads: signed/unsigned byte, upper signed half, word, dropped rd=0 load
      do_load("lb",  5'd7,  32'h0000_1002, 2'b00, 1'b0, 32'h0080_0000, 32'hFFFF_FF80, 3, 1'b1);
      do_load("lbu", 5'd7,  32'h0000_1002, 2'b00, 1'b1, 32'h0080_0000, 32'h0000_0080, 3, 1'b1);
      do_load("lh",  5'd8,  32'h0000_2003, 2'b01, 1'b0, 32'h8001_0000, 32'hFFFF_8001, 1, 1'b1);
      do_load("lb1", 5'd11, 32'h0000_0001, 2'b00, 1'b0, 32'h0000_7F00, 32'h0000_007F, 0, 1'b1);
      do_load("lw",  5'd6,  32'h0000_3001, 2'b10, 1'b0, 32'h8765_4321, 32'h8765_4321, 2, 1'b1);
      do_load("lx0", 5'd0,  32'h0000_0000, 2'b10, 1'b0, 32'h1111_1111, 32'h0, 2, 1'b0);

      // Single commit under a 4-cycle stall, then next entry accepted
      set_entry(1'b1, 5'd9, 32'h0000_00AA, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
      push_write(5'd9, 32'h0000_00AA);
      step();
      idle();
      stall = 1'b1;
      chk("stall_we_first", {31'd0, regwrite_en}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("stall_we_held", {31'd0, regwrite_en}, 32'd0);
         chk("stall_addr_held", {27'd0, write_addr}, 32'd9);
      end
      stall = 1'b0;
      set_entry(1'b1, 5'd10, 32'h0000_0055, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
      push_write(5'd10, 32'h0000_0055);
      step();
      idle();
      chk("post_stall_addr", {27'd0, write_addr}, 32'd10);
      step();

      // Stall and load data in the same cycle: captured, written once, then held
      set_entry(1'b1, 5'd12, 32'h0, 32'h0, 2'b01, 2'b10, 1'b0, 1'b0);
      step();
      idle();
      stall           = 1'b1;
      mem_rdata       = 32'hCAFE_F00D;
      mem_rdata_valid = 1'b1;
      push_write(5'd12, 32'hCAFE_F00D);
      step();
      mem_rdata_valid = 1'b0;
      chk("stmem_busy", {31'd0, wb_busy}, 32'd0);
      chk("stmem_we", {31'd0, regwrite_en}, 32'd1);
      step();
      chk("stmem_we_held", {31'd0, regwrite_en}, 32'd0);
      stall = 1'b0;
      step();
      chk("stmem_empty_addr", {27'd0, write_addr}, 32'd0);

      // Stray load data while empty is ignored
      mem_rdata       = 32'h0000_1234;
      mem_rdata_valid = 1'b1;
      step();
      mem_rdata_valid = 1'b0;
      chk("stray_busy", {31'd0, wb_busy}, 32'd0);
      chk("stray_we", {31'd0, regwrite_en}, 32'd0);

      // Flushed entry and x0 destination never write
`ifdef WB_RETIRE_COUNT_EN
      rc0 = retire_count;
`endif
      set_entry(1'b1, 5'd3, 32'h0000_0333, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1);
      step();
      idle();
      chk("flush_we", {31'd0, regwrite_en}, 32'd0);
      chk("flush_addr", {27'd0, write_addr}, 32'd0);
      set_entry(1'b1, 5'd0, 32'h0000_0777, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
      step();
      idle();
      chk("x0_we", {31'd0, regwrite_en}, 32'd0);
      step();
`ifdef WB_RETIRE_COUNT_EN
      chk("retire_count", retire_count, rc0 + 32'd1);
`endif

      // Async reset while waiting for load data
      set_entry(1'b1, 5'd4, 32'h0, 32'h0, 2'b01, 2'b10, 1'b0, 1'b0);
      step();
      idle();
      chk("arst_pre_busy", {31'd0, wb_busy}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", {31'd0, wb_busy}, 32'd0);
      chk("arst_we", {31'd0, regwrite_en}, 32'd0);
      @(negedge clk);
      rst             = 1'b0;
      mem_rdata       = 32'hFFFF_FFFF;
      mem_rdata_valid = 1'b1;
      step();
      step();
      mem_rdata_valid = 1'b0;
      chk("arst_late_busy", {31'd0, wb_busy}, 32'd0);
      chk("arst_late_we", {31'd0, regwrite_en}, 32'd0);
      repeat (2) step();

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL missing_writes observed=%0d pending expected=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline stage of the pipelined processor; sits directly upstream of the register file and drives its write port (write_addr, write_data, regwrite_en).
- Latches memory-stage results and waits for variable-latency load data.
- Aligns and sign/zero-extends load data, selects the writeback source (ALU, load, PC+4), and commits each instruction to the register file exactly once.

Parameters:
- ADDRESS_WIDTH, 5, register address width.
- DATA_WIDTH, 32, datapath width; byte/half extraction requires 32.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- stall  input  1  downstream/global hold; stage does not accept new entry.
- flush  input  1  incoming entry is converted to a bubble on capture.
- in_valid  input  1  incoming entry valid.
- in_regwrite  input  1  incoming entry writes a register.
- in_rd  input  ADDRESS_WIDTH  destination register.
- in_alu_result  input  DATA_WIDTH  ALU result / load address.
- in_pc_plus4  input  DATA_WIDTH  link value.
- in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 treated as ALU.
- in_load_size  input  2  00 byte, 01 half, 10/11 word.
- in_load_unsigned  input  1  1 = zero-extend, 0 = sign-extend.
- mem_rdata  input  DATA_WIDTH  raw data-memory read word.
- mem_rdata_valid  input  1  mem_rdata valid this cycle.
- wb_busy  output  1  waiting for load data; upstream must hold.
- write_addr  output  ADDRESS_WIDTH  to register file.
- write_data  output  DATA_WIDTH  to register file.
- regwrite_en  output  1  to register file.

Behaviour:
- Reset (async): state EMPTY, valid=0, committed=0, load buffer=0, all outputs 0.
- accept = !stall && !wb_busy.
- On a clock edge with accept:
  - Stage registers load all in_* fields.
  - valid <= in_valid && !flush.
  - committed <= 0.
- Next state after accept:
  - EMPTY if the captured entry is invalid.
  - WAIT_MEM if valid and in_wb_sel==01.
  - READY otherwise.
- States:
  - EMPTY: no write. Outputs idle at write_addr=0, write_data=0, regwrite_en=0.
  - WAIT_MEM: wb_busy=1, regwrite_en=0. On an edge with mem_rdata_valid=1, store the aligned load value in the buffer and go to READY. stall does not block this transition.
  - READY: regwrite_en = valid && regwrite && (rd!=0) && !committed. write_data is the selected source. committed <= 1 at the edge if the entry is held (accept=0). This guarantees exactly one register-file write per instruction.
- Load alignment, with offset = alu_result[1:0]:
  - byte: lane offset*8.
  - half: lane offset[1]*16; offset[0] ignored.
  - word: whole word, offset ignored.
  - Extension to DATA_WIDTH per in_load_unsigned.
- write_addr = stored rd whenever valid, else 0.
- Boundary conditions:
  - mem_rdata_valid outside WAIT_MEM is ignored.
  - flush does not affect an entry already in the stage; it is past the commit point.
  - A load entry with regwrite=0 or rd=0 still waits in WAIT_MEM for its data, then drops without a write.
  - stall and mem_rdata_valid in the same WAIT_MEM cycle: data is captured; the entry writes once in READY, then holds with committed=1 until accept.
  - Reset asserted mid-WAIT_MEM returns to EMPTY immediately; late mem_rdata_valid is ignored.
- Latency:
  - Non-load captured at edge N: regwrite_en high in cycle N..N+1; the register file writes at edge N+1.
  - Load: the write occurs one edge after the mem_rdata_valid edge.
- The register file's own write-to-read bypass covers same-cycle reads; this stage adds no bypass.

Optional Feature:
- Macro WB_RETIRE_COUNT_EN.
- Defined:
  - Adds output retire_count (32 bits), reset to 0.
  - Increments by 1 on each edge where a valid entry in READY is committed or leaves the stage uncommitted. Counts each instruction once, including regwrite=0 and rd=0 entries.
  - Wraps modulo 2^32.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- ALU writeback: in_valid=1, in_regwrite=1, in_rd=5, in_wb_sel=00, in_alu_result=0x0000_1234 -> cycle after capture: regwrite_en=1, write_addr=5, write_data=0x0000_1234 for exactly one cycle.
- Signed byte load: in_wb_sel=01, in_load_size=00, in_load_unsigned=0, in_alu_result=0x...2, in_rd=7; mem_rdata=0x0080_0000 arrives 3 cycles later:
  - wb_busy=1 for those cycles.
  - Then one write of 0xFFFF_FF80 to r7.
  - Repeat unsigned -> 0x0000_0080.
- Halfword load: offset=3, size=01, signed, mem_rdata=0x8001_0000 -> write_data=0xFFFF_8001 (upper lane).
- Single commit under stall: ALU entry rd=9, 0xAA captured, stall=1 for 4 cycles -> regwrite_en high only in the first cycle; stage holds; next entry is accepted after stall drops.
- Bubbles, x0, and flush: flush=1 during capture of in_rd=3 -> no write. in_rd=0, regwrite=1 -> regwrite_en stays 0. With WB_RETIRE_COUNT_EN, the rd=0 entry increments retire_count; the flushed entry does not.
- Async reset mid-load: assert rst while in WAIT_MEM -> wb_busy=0 and regwrite_en=0 immediately. mem_rdata_valid=1 after reset releases -> no write.
